// File: rtl/snd_pkg.sv
// Shared constants for the sound-core voices: the frequency divisor base
// table, LFSR tap positions, the divider halt threshold and the envelope
// direction encoding.
package snd_pkg;

  localparam int TIMER_W = 20;

  localparam logic [6:0] DIV_BASE [8] = '{7'd8, 7'd16, 7'd32, 7'd48,
                                          7'd64, 7'd80, 7'd96, 7'd112};

  localparam int LFSR_TAP0 = 0;
  localparam int LFSR_TAP1 = 1;
  localparam int SHORT_TAP = 6;

  localparam logic [3:0] SHIFT_HALT = 4'd14;
  localparam logic [3:0] SHIFT_MAX  = 4'd13;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } env_dir_t;

endpackage

// File: rtl/snd_envelope.sv
// Volume envelope shared by the sound-core voices. Direction and period are
// captured on start; every period-th tick the volume moves one step towards
// the rail and saturates there. A captured period of 0 freezes the volume.
import snd_pkg::*;

module snd_envelope #(
  parameter int VOL_W = 4,
  parameter int ENV_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic [VOL_W-1:0] vol_init,
  input  logic             env_dir,
  input  logic [ENV_W-1:0] env_period,
  output logic [VOL_W-1:0] volume
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  env_dir_t         dir_q;
  logic [ENV_W-1:0] period_q;
  logic [ENV_W-1:0] timer;

  // Start reloads everything; a tick counts the timer down and, on the tick
  // that would bring it to zero, reloads it and nudges the volume.
  always_ff @(posedge clk) begin
    if (reset) begin
      volume   <= '0;
      dir_q    <= ENV_DOWN;
      period_q <= '0;
      timer    <= '0;
    end else if (start) begin
      volume   <= vol_init;
      dir_q    <= env_dir_t'(env_dir);
      period_q <= env_period;
      timer    <= env_period;
    end else if (tick && (period_q != '0)) begin
      if (timer <= ENV_W'(1)) begin
        timer <= period_q;
        if ((dir_q == ENV_UP) && (volume != VOL_MAX))
          volume <= volume + VOL_W'(1);
        else if ((dir_q == ENV_DOWN) && (volume != '0))
          volume <= volume - VOL_W'(1);
      end else begin
        timer <= timer - ENV_W'(1);
      end
    end
  end

endmodule

// File: rtl/noise_channel_gen.sv
// Noise voice: LFSR stepped by a programmable divider, volume envelope,
// length counter and stereo panning with registered outputs.
// Optional macro NOISE_CH_DAC_GATE_EN: vol_init = 0 with env_dir = 0 turns
// the DAC off, blocking starts and stopping a running channel.
import snd_pkg::*;

module noise_channel_gen #(
  parameter int LFSR_W = 15,
  parameter int VOL_W  = 4,
  parameter int LEN_W  = 6,
  parameter int ENV_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             len_tick,
  input  logic             env_tick,
  input  logic [LEN_W-1:0] len_load,
  input  logic [VOL_W-1:0] vol_init,
  input  logic             env_dir,
  input  logic [ENV_W-1:0] env_period,
  input  logic [3:0]       clk_shift,
  input  logic             width_mode,
  input  logic [2:0]       div_code,
  input  logic             trigger,
  input  logic             len_en,
  input  logic             pan_l,
  input  logic             pan_r,
  output logic [VOL_W-1:0] left,
  output logic [VOL_W-1:0] right,
  output logic             active
);

  localparam logic [LEN_W:0] LEN_FULL = (LEN_W+1)'(1) << LEN_W;

  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [TIMER_W-1:0] freq_timer;
  logic [TIMER_W-1:0] reload_val;
  logic [3:0]         shift_eff;
  logic               halted;
  logic [LEN_W:0]     len_ctr;
  logic [VOL_W-1:0]   volume;
  logic [VOL_W-1:0]   sample;
  logic               start;
`ifdef NOISE_CH_DAC_GATE_EN
  logic               dac_off;
`endif

  // Start condition, optionally blocked while the DAC is gated off.
  always_comb begin
`ifdef NOISE_CH_DAC_GATE_EN
    dac_off = (vol_init == '0) && (env_dir == 1'b0);
    start   = trigger && !dac_off;
`else
    start   = trigger;
`endif
  end

  // Divider reload from the live shift/divisor; large shifts halt the LFSR.
  always_comb begin
    halted     = (clk_shift >= SHIFT_HALT);
    shift_eff  = halted ? SHIFT_MAX : clk_shift;
    reload_val = (TIMER_W'(DIV_BASE[div_code]) << shift_eff) - TIMER_W'(1);
  end

  // One LFSR step; short mode also feeds the new bit into bit 6.
  always_comb begin
    lfsr_next = {lfsr[LFSR_TAP0] ^ lfsr[LFSR_TAP1], lfsr[LFSR_W-1:1]};
    if (width_mode)
      lfsr_next[SHORT_TAP] = lfsr[LFSR_TAP0] ^ lfsr[LFSR_TAP1];
  end

  // Frequency timer and LFSR keep running whether or not the channel is active.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= '1;
      freq_timer <= '0;
    end else if (start) begin
      lfsr       <= '1;
      freq_timer <= reload_val;
    end else if (freq_timer == '0) begin
      freq_timer <= reload_val;
      if (!halted)
        lfsr <= lfsr_next;
    end else begin
      freq_timer <= freq_timer - TIMER_W'(1);
    end
  end

  // Length counter owns the active flag; start wins over a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      len_ctr <= '0;
    end else if (start) begin
      active  <= 1'b1;
      len_ctr <= LEN_FULL - {1'b0, len_load};
`ifdef NOISE_CH_DAC_GATE_EN
    end else if (active && dac_off) begin
      active  <= 1'b0;
`endif
    end else if (len_tick && len_en && active && (len_ctr != '0)) begin
      len_ctr <= len_ctr - (LEN_W+1)'(1);
      if (len_ctr == (LEN_W+1)'(1))
        active <= 1'b0;
    end
  end

  snd_envelope #(
    .VOL_W(VOL_W),
    .ENV_W(ENV_W)
  ) u_env (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (env_tick && active),
    .vol_init   (vol_init),
    .env_dir    (env_dir),
    .env_period (env_period),
    .volume     (volume)
  );

  // Current sample is the volume when running and the LFSR output bit is low.
  always_comb begin
    sample = (active && !lfsr[0]) ? volume : '0;
  end

  // Registered panned outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      left  <= '0;
      right <= '0;
    end else begin
      left  <= pan_l ? sample : '0;
      right <= pan_r ? sample : '0;
    end
  end

endmodule

// File: tb/tb_noise_channel_gen.sv
// Directed bench for noise_channel_gen with hand-computed expectations.
module tb_noise_channel_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       len_tick;
  logic       env_tick;
  logic [5:0] len_load;
  logic [3:0] vol_init;
  logic       env_dir;
  logic [2:0] env_period;
  logic [3:0] clk_shift;
  logic       width_mode;
  logic [2:0] div_code;
  logic       trigger;
  logic       len_en;
  logic       pan_l;
  logic       pan_r;
  logic [3:0] left;
  logic [3:0] right;
  logic       active;

  int compared   = 0;
  int mismatched = 0;
  int early_hits = 0;

  noise_channel_gen dut (
    .clk        (clk),
    .reset      (reset),
    .len_tick   (len_tick),
    .env_tick   (env_tick),
    .len_load   (len_load),
    .vol_init   (vol_init),
    .env_dir    (env_dir),
    .env_period (env_period),
    .clk_shift  (clk_shift),
    .width_mode (width_mode),
    .div_code   (div_code),
    .trigger    (trigger),
    .len_en     (len_en),
    .pan_l      (pan_l),
    .pan_r      (pan_r),
    .left       (left),
    .right      (right),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulseTrigger();
    trigger = 1'b1;
    applyStimulus(1);
    trigger = 1'b0;
  endtask

  task automatic envTicks(input int n);
    repeat (n) begin
      env_tick = 1'b1;
      applyStimulus(1);
      env_tick = 1'b0;
      applyStimulus(1);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; len_tick = 1'b0; env_tick = 1'b0; len_load = 6'd0;
    vol_init = 4'd5; env_dir = 1'b0; env_period = 3'd0; clk_shift = 4'd0;
    width_mode = 1'b0; div_code = 3'd0; trigger = 1'b0; len_en = 1'b0;
    pan_l = 1'b1; pan_r = 1'b1;

    applyStimulus(3);
    reset = 1'b0;
    checkOutput("rst_lfsr", dut.lfsr, 32'h7FFF);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_left", left, 0);
    checkOutput("rst_right", right, 0);

    // Long-mode stepping every 8 clocks.
    pulseTrigger();
    checkOutput("trig_active", active, 1);
    checkOutput("trig_volume", dut.volume, 5);
    checkOutput("trig_lfsr", dut.lfsr, 32'h7FFF);
    checkOutput("trig_left_latency", left, 0);
    applyStimulus(7);
    checkOutput("lfsr_before_step", dut.lfsr, 32'h7FFF);
    applyStimulus(1);
    checkOutput("lfsr_step1", dut.lfsr, 32'h3FFF);
    applyStimulus(112);
    checkOutput("lfsr_step15", dut.lfsr, 32'h4000);
    applyStimulus(1);
    checkOutput("sample_left", left, 5);
    checkOutput("sample_right", right, 5);

    // Reset while running.
    reset = 1'b1;
    applyStimulus(3);
    reset = 1'b0;
    checkOutput("rrst_left", left, 0);
    checkOutput("rrst_right", right, 0);
    checkOutput("rrst_active", active, 0);
    checkOutput("rrst_lfsr", dut.lfsr, 32'h7FFF);
    checkOutput("rrst_volume", dut.volume, 0);

    // Length 63 expires on the first tick.
    len_load = 6'd63; len_en = 1'b1;
    pulseTrigger();
    checkOutput("len63_ctr", dut.len_ctr, 1);
    checkOutput("len63_active", active, 1);
    applyStimulus(120);
    applyStimulus(1);
    checkOutput("len63_left_running", left, 5);
    len_tick = 1'b1;
    applyStimulus(1);
    len_tick = 1'b0;
    checkOutput("len63_active_drop", active, 0);
    checkOutput("len63_ctr_zero", dut.len_ctr, 0);
    applyStimulus(1);
    checkOutput("len63_left_off", left, 0);
    checkOutput("len63_right_off", right, 0);

    // Length hold, decrement, and trigger winning over a coincident tick.
    len_load = 6'd62; len_en = 1'b0;
    pulseTrigger();
    len_tick = 1'b1;
    applyStimulus(1);
    len_tick = 1'b0;
    checkOutput("len_hold_ctr", dut.len_ctr, 2);
    len_en = 1'b1; len_tick = 1'b1;
    applyStimulus(1);
    len_tick = 1'b0;
    checkOutput("len_dec_ctr", dut.len_ctr, 1);
    trigger = 1'b1; len_tick = 1'b1;
    applyStimulus(1);
    trigger = 1'b0; len_tick = 1'b0;
    checkOutput("trig_vs_tick_active", active, 1);
    checkOutput("trig_vs_tick_ctr", dut.len_ctr, 2);
    len_en = 1'b0; pan_r = 1'b0;
    applyStimulus(121);
    checkOutput("pan_left", left, 5);
    checkOutput("pan_right_off", right, 0);
    pan_r = 1'b1;

    // Envelope down, period 3.
    vol_init = 4'd7; env_dir = 1'b0; env_period = 3'd3;
    pulseTrigger();
    checkOutput("env_dn_init", dut.volume, 7);
    envTicks(3);
    checkOutput("env_dn_t3", dut.volume, 6);
    envTicks(2);
    checkOutput("env_dn_t5", dut.volume, 6);
    envTicks(1);
    checkOutput("env_dn_t6", dut.volume, 5);
    envTicks(15);
    checkOutput("env_dn_t21", dut.volume, 0);
    envTicks(3);
    checkOutput("env_dn_floor", dut.volume, 0);

    // Envelope up saturates at 15.
    vol_init = 4'd14; env_dir = 1'b1; env_period = 3'd1;
    pulseTrigger();
    envTicks(1);
    checkOutput("env_up_15", dut.volume, 15);
    envTicks(1);
    checkOutput("env_up_sat", dut.volume, 15);

    // Period 0 freezes the volume.
    vol_init = 4'd9; env_dir = 1'b0; env_period = 3'd0;
    pulseTrigger();
    envTicks(3);
    checkOutput("env_frozen", dut.volume, 9);

    // Divider: div_code 1, shift 1 gives 32 clocks per step.
    div_code = 3'd1; clk_shift = 4'd1;
    pulseTrigger();
    applyStimulus(31);
    checkOutput("div32_before", dut.lfsr, 32'h7FFF);
    applyStimulus(1);
    checkOutput("div32_step", dut.lfsr, 32'h3FFF);

    // Shift 14 halts the LFSR at the next reload.
    div_code = 3'd0; clk_shift = 4'd0;
    pulseTrigger();
    clk_shift = 4'd14;
    applyStimulus(9);
    checkOutput("halt_lfsr", dut.lfsr, 32'h7FFF);

    // Short mode repeats after 127 steps.
    clk_shift = 4'd0; width_mode = 1'b1;
    pulseTrigger();
    for (int k = 1; k <= 127; k++) begin
      applyStimulus(8);
      if ((k < 127) && (dut.lfsr[6:0] == 7'h7F))
        early_hits++;
    end
    checkOutput("short_early_repeat", early_hits, 0);
    checkOutput("short_period_127", {25'd0, dut.lfsr[6:0]}, 32'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
